// File: rtl/pe_reconfig.sv
// pe_reconfig -- reconfigurable systolic-array processing element.
//
// One tile of an N->S / W->E array. At run time it acts either as an
// output-stationary PE (accumulates locally, drains down the column) or as a
// weight-stationary PE (holds a weight from a shift chain and adds its
// product into the partial sum flowing south). Operands may be signed or
// unsigned, and a sticky flag records any accumulator/partial-sum overflow.
//
// Build option:
//   PE_RECONFIG_SAT_EN  when defined, an overflowing sum clamps to the
//                       representable limit instead of wrapping modulo
//                       2^WACC. The ovf flag behaves the same in both builds.
//
// Parameters:
//   WDATA  operand width (in_data_N, in_data_W, weight register)
//   WACC   accumulator / partial-sum width, must be >= 2*WDATA
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset, clears every register
//   pe_enable    compute strobe
//   mode         0 = output-stationary, 1 = weight-stationary
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   clear_acc    OS: start a new tile (also clears ovf)
//   load_w       WS: shift the weight chain
//   drain        OS: shift accumulators down the column
//   in_data_N    north operand / weight-chain input
//   in_data_W    west operand
//   in_psum_N    partial sum (WS) or drain data (OS) from above
//   out_data_S   registered south operand / weight-chain output
//   out_data_E   registered east operand
//   out_psum_S   registered partial sum / drain output
//   result       current accumulator value
//   ovf          sticky overflow flag
module pe_reconfig #(
    parameter int WDATA = 8,
    parameter int WACC  = 2*WDATA+4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pe_enable,
    input  logic             mode,
    input  logic             signed_mode,
    input  logic             clear_acc,
    input  logic             load_w,
    input  logic             drain,
    input  logic [WDATA-1:0] in_data_N,
    input  logic [WDATA-1:0] in_data_W,
    input  logic [WACC-1:0]  in_psum_N,
    output logic [WDATA-1:0] out_data_S,
    output logic [WDATA-1:0] out_data_E,
    output logic [WACC-1:0]  out_psum_S,
    output logic [WACC-1:0]  result,
    output logic             ovf
);

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } mode_t;

    // Architectural state
    logic [WACC-1:0]  acc;
    logic [WDATA-1:0] weight;
    logic             weight_valid;
    mode_t            mode_q;

    // Next-state values
    logic [WACC-1:0]  acc_nxt;
    logic [WDATA-1:0] weight_nxt;
    logic             weight_valid_nxt;
    mode_t            mode_nxt;
    logic             ovf_nxt;
    logic [WDATA-1:0] data_s_nxt;
    logic [WDATA-1:0] data_e_nxt;
    logic [WACC-1:0]  psum_s_nxt;

    // Datapath
    logic [WDATA-1:0]   mul_a;
    logic [2*WDATA-1:0] mul_a_ext;
    logic [2*WDATA-1:0] mul_b_ext;
    logic [2*WDATA-1:0] prod;
    logic [WACC-1:0]    product;
    logic [WACC:0]      acc_sum;
    logic [WACC:0]      psum_sum;

    // Adds two WACC-bit values under the current signedness and returns
    // {overflow, sum}. Signed overflow: operands agree in sign but the sum
    // does not. Unsigned overflow: carry out of the top bit.
    function automatic logic [WACC:0] add_check(
        input logic [WACC-1:0] a,
        input logic [WACC-1:0] b,
        input logic            is_signed
    );
        logic [WACC:0]   wide;
        logic [WACC-1:0] res;
        logic            of;
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WACC-1:0];
        if (is_signed) begin
            of = (a[WACC-1] == b[WACC-1]) && (wide[WACC-1] != a[WACC-1]);
        end else begin
            of = wide[WACC];
        end
`ifdef PE_RECONFIG_SAT_EN
        // Clamp toward the side the operands were heading: both positive
        // saturates high, both negative saturates low.
        if (of) begin
            if (is_signed) begin
                res = a[WACC-1] ? {1'b1, {(WACC-1){1'b0}}}
                                : {1'b0, {(WACC-1){1'b1}}};
            end else begin
                res = {WACC{1'b1}};
            end
        end
`endif
        return {of, res};
    endfunction

    // The multiplier's north operand is the incoming data in OS and the
    // stationary weight in WS.
    assign mul_a = (mode_q == MODE_WS) ? weight : in_data_N;

    // Both operands are widened to 2*WDATA before multiplying; the low
    // 2*WDATA bits of that product are exact for signed and unsigned alike.
    assign mul_a_ext = signed_mode ? {{WDATA{mul_a[WDATA-1]}}, mul_a}
                                   : {{WDATA{1'b0}}, mul_a};
    assign mul_b_ext = signed_mode ? {{WDATA{in_data_W[WDATA-1]}}, in_data_W}
                                   : {{WDATA{1'b0}}, in_data_W};
    assign prod      = mul_a_ext * mul_b_ext;
    assign product   = signed_mode ? WACC'($signed(prod)) : WACC'(prod);

    assign acc_sum  = add_check(clear_acc ? {WACC{1'b0}} : acc, product, signed_mode);
    assign psum_sum = add_check(in_psum_N, weight_valid ? product : {WACC{1'b0}},
                                signed_mode);

    assign result = acc;

    // Next-state selection. A mode change pre-empts every other action for
    // one cycle so the array flushes cleanly; otherwise drain beats load_w
    // beats pe_enable, with commands that do not apply to the current mode
    // falling through to the next one in line.
    always_comb begin
        acc_nxt          = acc;
        weight_nxt       = weight;
        weight_valid_nxt = weight_valid;
        mode_nxt         = mode_q;
        ovf_nxt          = ovf;
        data_s_nxt       = out_data_S;
        data_e_nxt       = out_data_E;
        psum_s_nxt       = out_psum_S;

        if (mode_t'(mode) != mode_q) begin
            mode_nxt         = mode_t'(mode);
            acc_nxt          = {WACC{1'b0}};
            weight_valid_nxt = 1'b0;
            ovf_nxt          = 1'b0;
        end else if (mode_q == MODE_OS) begin
            if (drain) begin
                psum_s_nxt = acc;
                acc_nxt    = in_psum_N;
            end else if (pe_enable) begin
                data_s_nxt = in_data_N;
                data_e_nxt = in_data_W;
                acc_nxt    = acc_sum[WACC-1:0];
                ovf_nxt    = (clear_acc ? 1'b0 : ovf) | acc_sum[WACC];
            end else if (clear_acc) begin
                acc_nxt = {WACC{1'b0}};
                ovf_nxt = 1'b0;
            end
        end else begin
            if (load_w) begin
                weight_nxt       = in_data_N;
                data_s_nxt       = weight;
                weight_valid_nxt = 1'b1;
            end else if (pe_enable) begin
                data_e_nxt = in_data_W;
                psum_s_nxt = psum_sum[WACC-1:0];
                ovf_nxt    = ovf | psum_sum[WACC];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            weight       <= '0;
            weight_valid <= 1'b0;
            mode_q       <= MODE_OS;
            ovf          <= 1'b0;
            out_data_S   <= '0;
            out_data_E   <= '0;
            out_psum_S   <= '0;
        end else begin
            acc          <= acc_nxt;
            weight       <= weight_nxt;
            weight_valid <= weight_valid_nxt;
            mode_q       <= mode_nxt;
            ovf          <= ovf_nxt;
            out_data_S   <= data_s_nxt;
            out_data_E   <= data_e_nxt;
            out_psum_S   <= psum_s_nxt;
        end
    end

endmodule

// File: tb/tb_pe_reconfig.sv
// tb_pe_reconfig -- self-checking bench for pe_reconfig (WDATA=8, WACC=20).
// Directed steps from the block's scenarios followed by a randomized run,
// all compared against an arithmetic reference model of the PE.
module tb_pe_reconfig;

    localparam int WDATA = 8;
    localparam int WACC  = 20;

    logic             clk;
    logic             rst_n;
    logic             pe_enable;
    logic             mode;
    logic             signed_mode;
    logic             clear_acc;
    logic             load_w;
    logic             drain;
    logic [WDATA-1:0] in_data_N;
    logic [WDATA-1:0] in_data_W;
    logic [WACC-1:0]  in_psum_N;
    logic [WDATA-1:0] out_data_S;
    logic [WDATA-1:0] out_data_E;
    logic [WACC-1:0]  out_psum_S;
    logic [WACC-1:0]  result;
    logic             ovf;

    int tests_run = 0;
    int fails     = 0;

    // Reference model state
    logic [WACC-1:0]  m_acc;
    logic [WACC-1:0]  m_psum;
    logic [WDATA-1:0] m_weight;
    logic [WDATA-1:0] m_s;
    logic [WDATA-1:0] m_e;
    bit               m_wv;
    bit               m_mode;
    bit               m_ovf;

    pe_reconfig #(.WDATA(WDATA), .WACC(WACC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pe_enable  (pe_enable),
        .mode       (mode),
        .signed_mode(signed_mode),
        .clear_acc  (clear_acc),
        .load_w     (load_w),
        .drain      (drain),
        .in_data_N  (in_data_N),
        .in_data_W  (in_data_W),
        .in_psum_N  (in_psum_N),
        .out_data_S (out_data_S),
        .out_data_E (out_data_E),
        .out_psum_S (out_psum_S),
        .result     (result),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Numeric value of an operand or sum under the current signedness
    function automatic longint op_val(input logic [WDATA-1:0] x);
        return signed_mode ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic longint sum_val(input logic [WACC-1:0] x);
        return signed_mode ? longint'($signed(x)) : longint'(x);
    endfunction

    // Exact integer addition, then range check and wrap (or clamp)
    task automatic model_add(input longint a, input longint b,
                             output logic [WACC-1:0] r, output bit of);
        longint s, lo, hi;
        s = a + b;
        if (signed_mode) begin
            lo = -(longint'(1) << (WACC-1));
            hi = (longint'(1) << (WACC-1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << WACC) - 1;
        end
        of = (s < lo) || (s > hi);
        r  = s[WACC-1:0];
`ifdef PE_RECONFIG_SAT_EN
        if (s > hi) r = hi[WACC-1:0];
        else if (s < lo) r = lo[WACC-1:0];
`endif
    endtask

    task automatic model_reset();
        m_acc = '0; m_psum = '0; m_weight = '0; m_s = '0; m_e = '0;
        m_wv = 0; m_mode = 0; m_ovf = 0;
    endtask

    // One clock of PE behaviour given the inputs currently driven
    task automatic model_step();
        logic [WACC-1:0] r;
        bit of;
        longint prod;
        if (mode != m_mode) begin
            m_mode = mode; m_acc = '0; m_wv = 0; m_ovf = 0;
        end else if (!m_mode) begin
            if (drain) begin
                m_psum = m_acc;
                m_acc  = in_psum_N;
            end else if (pe_enable) begin
                m_s  = in_data_N;
                m_e  = in_data_W;
                prod = op_val(in_data_N) * op_val(in_data_W);
                model_add(clear_acc ? 0 : sum_val(m_acc), prod, r, of);
                m_acc = r;
                m_ovf = (clear_acc ? 1'b0 : m_ovf) | of;
            end else if (clear_acc) begin
                m_acc = '0; m_ovf = 0;
            end
        end else begin
            if (load_w) begin
                m_s      = m_weight;
                m_weight = in_data_N;
                m_wv     = 1;
            end else if (pe_enable) begin
                m_e  = in_data_W;
                prod = m_wv ? op_val(m_weight) * op_val(in_data_W) : 0;
                model_add(sum_val(in_psum_N), prod, r, of);
                m_psum = r;
                m_ovf  = m_ovf | of;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        chk({tag, ".result"},     32'(result),     32'(m_acc));
        chk({tag, ".out_psum_S"}, 32'(out_psum_S), 32'(m_psum));
        chk({tag, ".out_data_S"}, 32'(out_data_S), 32'(m_s));
        chk({tag, ".out_data_E"}, 32'(out_data_E), 32'(m_e));
        chk({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".result"},     32'(result),     32'h0);
        chk({tag, ".out_psum_S"}, 32'(out_psum_S), 32'h0);
        chk({tag, ".out_data_S"}, 32'(out_data_S), 32'h0);
        chk({tag, ".out_data_E"}, 32'(out_data_E), 32'h0);
        chk({tag, ".ovf"},        32'(ovf),        32'h0);
    endtask

    task automatic set_idle();
        pe_enable = 0; clear_acc = 0; load_w = 0; drain = 0;
    endtask

    // Advance one clock with the driven inputs; sample 1 time unit later
    task automatic apply_stimulus();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; mode = 0; signed_mode = 0;
        set_idle();
        in_data_N = '0; in_data_W = '0; in_psum_N = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;

        // OS unsigned: 3*5 over 4 cycles, clear on the first
        pe_enable = 1; clear_acc = 1; in_data_N = 8'd3; in_data_W = 8'd5;
        apply_stimulus();
        chk("os_u_lat.out_data_S", 32'(out_data_S), 32'd3);
        chk("os_u_lat.out_data_E", 32'(out_data_E), 32'd5);
        chk("os_u_lat.result", 32'(result), 32'd15);
        clear_acc = 0;
        repeat (3) apply_stimulus();
        chk("os_u.result", 32'(result), 32'd60);
        chk("os_u.ovf", 32'(ovf), 32'd0);
        check_output("os_u");

        // Drain beats pe_enable; operand outputs hold
        drain = 1; pe_enable = 1; in_psum_N = 20'd9; in_data_N = 8'd77; in_data_W = 8'd88;
        apply_stimulus();
        chk("drain.out_psum_S", 32'(out_psum_S), 32'd60);
        chk("drain.result", 32'(result), 32'd9);
        chk("drain.out_data_S", 32'(out_data_S), 32'd3);
        chk("drain.out_data_E", 32'(out_data_E), 32'd5);

        // Mode toggle clears acc and does nothing else, even with enable high
        set_idle();
        mode = 1; pe_enable = 1; in_psum_N = 20'd500; in_data_W = 8'd11;
        apply_stimulus();
        chk("mode_sw.result", 32'(result), 32'd0);
        chk("mode_sw.out_psum_S", 32'(out_psum_S), 32'd60);
        chk("mode_sw.out_data_E", 32'(out_data_E), 32'd5);

        // WS: compute before any weight is loaded passes psum through
        in_psum_N = 20'd100; in_data_W = 8'd6;
        apply_stimulus();
        chk("ws_noload.out_psum_S", 32'(out_psum_S), 32'd100);
        chk("ws_noload.out_data_E", 32'(out_data_E), 32'd6);
        set_idle();
        load_w = 1; in_data_N = 8'd4;
        apply_stimulus();
        chk("ws_load.out_data_S", 32'(out_data_S), 32'd0);
        set_idle();
        pe_enable = 1; in_data_W = 8'd6; in_psum_N = 20'd100;
        apply_stimulus();
        chk("ws_mac.out_psum_S", 32'(out_psum_S), 32'd124);
        load_w = 1; pe_enable = 1; in_data_N = 8'd9; in_data_W = 8'd1; in_psum_N = 20'd0;
        apply_stimulus();
        chk("ws_loadprio.out_psum_S", 32'(out_psum_S), 32'd124);
        chk("ws_loadprio.out_data_S", 32'(out_data_S), 32'd4);
        chk("ws_loadprio.out_data_E", 32'(out_data_E), 32'd6);
        check_output("ws");

        // Back to OS, then signed accumulation of -2*7 over 3 cycles
        set_idle();
        mode = 0;
        apply_stimulus();
        signed_mode = 1; pe_enable = 1; clear_acc = 1; in_data_N = 8'hFE; in_data_W = 8'd7;
        apply_stimulus();
        clear_acc = 0;
        repeat (2) apply_stimulus();
        chk("os_s.result", 32'(result), 32'hFFFD6);
        chk("os_s.ovf", 32'(ovf), 32'd0);
        check_output("os_s");

        // Unsigned overflow: 255*255 accumulated 16 then 17 times
        signed_mode = 0; clear_acc = 1; in_data_N = 8'd255; in_data_W = 8'd255;
        apply_stimulus();
        clear_acc = 0;
        repeat (15) apply_stimulus();
        chk("ovf16.result", 32'(result), 32'd1040400);
        chk("ovf16.ovf", 32'(ovf), 32'd0);
        apply_stimulus();
        chk("ovf17.ovf", 32'(ovf), 32'd1);
`ifdef PE_RECONFIG_SAT_EN
        chk("ovf17.result", 32'(result), 32'hFFFFF);
`else
        chk("ovf17.result", 32'(result), 32'd56849);
`endif
        check_output("ovf17");
        set_idle();
        apply_stimulus();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clear_acc = 1;
        apply_stimulus();
        chk("ovf_clear", 32'(ovf), 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            pe_enable   = ($urandom_range(0, 3) != 0);
            drain       = ($urandom_range(0, 7) == 0);
            load_w      = ($urandom_range(0, 4) == 0);
            clear_acc   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            if ($urandom_range(0, 29) == 0) signed_mode = ~signed_mode;
            in_data_N = WDATA'($urandom);
            in_data_W = WDATA'($urandom);
            in_psum_N = ($urandom_range(0, 1) == 0) ? WACC'($urandom) : WACC'($urandom_range(0, 255));
            apply_stimulus();
            check_output("rand");
        end

        // Async reset between edges, then a fresh compute
        set_idle();
        mode = 0; signed_mode = 0;
        pe_enable = 1; in_data_N = 8'd13; in_data_W = 8'd17; in_psum_N = 20'd1;
        apply_stimulus();
        apply_stimulus();
        drain = 1;
        apply_stimulus();
        set_idle();
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        check_all_zero("rst_hold");
        pe_enable = 1; clear_acc = 0; in_data_N = 8'd2; in_data_W = 8'd2;
        apply_stimulus();
        chk("post_rst.result", 32'(result), 32'd4);
        check_output("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
